// File: rtl/cog_vid_seq_pkg.sv
// Shared types for the cog video sequencer: FSM state encoding and colour helpers.
package cog_vid_seq_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoadScl = 3'd1,
    StPrime   = 3'd2,
    StLoadVid = 3'd3,
    StRun     = 3'd4,
    StHalt    = 3'd5
  } state_e;

  // Underrun colour: the blank byte replicated into all four colour slots.
  function automatic logic [31:0] blank_color(input logic [7:0] b);
    return {4{b}};
  endfunction

endpackage

// File: rtl/cog_vid_fifo.sv
// Synchronous FIFO with async active-low clear; read data is the head entry, not prefetched.
module cog_vid_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk_cog,
  input  logic             ena,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot this cycle, so a push at full is still accepted.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk_cog or negedge ena) begin
    if (!ena) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_cog) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cog_vid_seq.sv
// Cog video sequencer: buffers pixel/colour pairs, programs VSCL/VCFG and feeds the
// video generator one pair per rising ack, flagging underrun/overflow.
module cog_vid_seq
  import cog_vid_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LW    = 10,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_cog,
  input  logic          ena,
  input  logic          start,
  input  logic          stop,
  input  logic [31:0]   cfg_vid,
  input  logic [31:0]   cfg_scl,
  input  logic [LW-1:0] line_words,
  input  logic [7:0]    blank,
  input  logic          push,
  input  logic [31:0]   push_pixel,
  input  logic [31:0]   push_color,
  input  logic          ack,
  output logic          setscl,
  output logic          setvid,
  output logic [31:0]   data,
  output logic [31:0]   pixel,
  output logic [31:0]   color,
  output logic [AW:0]   level,
  output logic          full,
  output logic          busy,
  output logic          line_done,
  output logic          underrun,
  output logic          overflow
);

  state_e        state_q;
  logic          ack_q, ack_edge;
  logic [LW-1:0] word_cnt_q;
  logic          last_word;
  logic          fifo_pop, fifo_empty, fifo_drop;
  logic [63:0]   fifo_rdata;

  assign ack_edge  = ack & ~ack_q;
  // line_words==0 wraps to all-ones, giving a 2^LW line length.
  assign last_word = (word_cnt_q == line_words - 1'b1);
  assign busy      = (state_q != StIdle);
  assign fifo_pop  = ~fifo_empty & ~stop &
                     ((state_q == StPrime) | ((state_q == StRun) & ack_edge));

  cog_vid_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk_cog (clk_cog),
    .ena     (ena),
    .push    (push),
    .wdata   ({push_pixel, push_color}),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .level   (level),
    .full    (full),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  always_ff @(posedge clk_cog or negedge ena) begin
    if (!ena) begin
      state_q    <= StIdle;
      ack_q      <= 1'b0;
      word_cnt_q <= '0;
      setscl     <= 1'b0;
      setvid     <= 1'b0;
      data       <= '0;
      pixel      <= '0;
      color      <= '0;
      line_done  <= 1'b0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ack_q     <= ack;
      setscl    <= 1'b0;
      setvid    <= 1'b0;
      data      <= '0;
      line_done <= 1'b0;
      if (stop && state_q != StIdle) begin
        // Disable strobe: setvid with zero data, pixel/colour hold.
        state_q <= StHalt;
        setvid  <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q    <= StLoadScl;
              setscl     <= 1'b1;
              data       <= cfg_scl;
              underrun   <= 1'b0;
              overflow   <= 1'b0;
              word_cnt_q <= '0;
            end
          end
          StLoadScl: state_q <= StPrime;
          StPrime: begin
            if (!fifo_empty) begin
              pixel   <= fifo_rdata[63:32];
              color   <= fifo_rdata[31:0];
              state_q <= StLoadVid;
              setvid  <= 1'b1;
              data    <= cfg_vid;
            end
          end
          StLoadVid: state_q <= StRun;
          StRun: begin
            if (ack_edge) begin
              if (fifo_empty) begin
                pixel    <= '0;
                color    <= blank_color(blank);
                underrun <= 1'b1;
              end else begin
                pixel <= fifo_rdata[63:32];
                color <= fifo_rdata[31:0];
              end
              if (last_word) begin
                word_cnt_q <= '0;
                line_done  <= 1'b1;
              end else begin
                word_cnt_q <= word_cnt_q + 1'b1;
              end
            end
          end
          StHalt:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
      if (fifo_drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cog_vid_seq.sv
// Scenario bench for cog_vid_seq with a scoreboard of pushed pixel/colour pairs.
module tb_cog_vid_seq;

  localparam int DEPTH = 8;
  localparam int LW    = 10;

  logic          clk_cog;
  logic          ena;
  logic          start, stop, push, ack;
  logic [31:0]   cfg_vid, cfg_scl, push_pixel, push_color;
  logic [LW-1:0] line_words;
  logic [7:0]    blank;
  logic          setscl, setvid, full, busy, line_done, underrun, overflow;
  logic [31:0]   data, pixel, color;
  logic [$clog2(DEPTH):0] level;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb[$];

  cog_vid_seq #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) dut (
    .clk_cog    (clk_cog),
    .ena        (ena),
    .start      (start),
    .stop       (stop),
    .cfg_vid    (cfg_vid),
    .cfg_scl    (cfg_scl),
    .line_words (line_words),
    .blank      (blank),
    .push       (push),
    .push_pixel (push_pixel),
    .push_color (push_color),
    .ack        (ack),
    .setscl     (setscl),
    .setvid     (setvid),
    .data       (data),
    .pixel      (pixel),
    .color      (color),
    .level      (level),
    .full       (full),
    .busy       (busy),
    .line_done  (line_done),
    .underrun   (underrun),
    .overflow   (overflow)
  );

  initial clk_cog = 1'b0;
  always #5 clk_cog = ~clk_cog;

  // One-cycle push; the entry is expected in the scoreboard only if accepted.
  task automatic push_entry(input logic [31:0] p, input logic [31:0] c, input bit accept);
    push = 1'b1; push_pixel = p; push_color = c;
    @(negedge clk_cog);
    push = 1'b0;
    if (accept) sb.push_back({p, c});
  endtask

  task automatic test_reset();
    ena = 1'b0; start = 0; stop = 0; push = 0; ack = 0;
    cfg_vid = '0; cfg_scl = '0; push_pixel = '0; push_color = '0;
    line_words = 10'd4; blank = 8'h00;
    repeat (3) @(negedge clk_cog);
    checks++;
    if ({setscl, setvid, data, pixel, color, full, busy, line_done, underrun, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got setscl=%b setvid=%b data=%h pixel=%h color=%h flags=%b%b%b%b%b want all 0",
               setscl, setvid, data, pixel, color, full, busy, line_done, underrun, overflow);
    end
    checks++;
    if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    ena = 1'b1;
    @(negedge clk_cog);
  endtask

  task automatic test_prime();
    logic [63:0] exp;
    push_entry(32'hA000_0001, 32'hC000_0001, 1'b1);
    push_entry(32'hA000_0002, 32'hC000_0002, 1'b1);
    checks++;
    if (level !== 4'd2) begin errors++; $display("FAIL prime_level2: got %0d want 2", level); end
    cfg_scl = 32'h0000_4010; cfg_vid = 32'h2000_00FF;
    start = 1'b1;
    @(negedge clk_cog);
    start = 1'b0;
    checks++;
    if (setscl !== 1'b1 || data !== 32'h0000_4010 || setvid !== 1'b0) begin
      errors++;
      $display("FAIL prime_setscl: got setscl=%b setvid=%b data=%h want 1 0 00004010", setscl, setvid, data);
    end
    @(negedge clk_cog);
    checks++;
    if (setscl !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL prime_scl_1cyc: got setscl=%b busy=%b want 0 1", setscl, busy);
    end
    @(negedge clk_cog);
    exp = sb.pop_front();
    checks++;
    if (setvid !== 1'b1 || data !== 32'h2000_00FF || {pixel, color} !== exp || level !== 4'd1) begin
      errors++;
      $display("FAIL prime_setvid: got setvid=%b data=%h pair=%h level=%0d want 1 200000FF %h 1",
               setvid, data, {pixel, color}, level, exp);
    end
    @(negedge clk_cog);
    checks++;
    if (setvid !== 1'b0 || data !== 32'h0 || busy !== 1'b1) begin
      errors++; $display("FAIL prime_run: got setvid=%b data=%h busy=%b want 0 0 1", setvid, data, busy);
    end
  endtask

  task automatic test_ack_pop();
    logic [63:0] exp;
    ack = 1'b1;
    repeat (2) @(negedge clk_cog);
    ack = 1'b0;
    exp = sb.pop_front();
    checks++;
    if ({pixel, color} !== exp || level !== 4'd0) begin
      errors++;
      $display("FAIL ack_pop: got pair=%h level=%0d want %h 0", {pixel, color}, level, exp);
    end
    @(negedge clk_cog);
    checks++;
    if ({pixel, color} !== exp || underrun !== 1'b0) begin
      errors++;
      $display("FAIL ack_single_pop: got pair=%h underrun=%b want %h 0", {pixel, color}, underrun, exp);
    end
  endtask

  task automatic test_underrun();
    blank = 8'h02;
    ack = 1'b1;
    @(negedge clk_cog);
    ack = 1'b0;
    checks++;
    if (pixel !== 32'h0 || color !== 32'h0202_0202 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun: got pixel=%h color=%h underrun=%b want 0 02020202 1", pixel, color, underrun);
    end
    @(negedge clk_cog);
  endtask

  task automatic test_stop_with_ack();
    push_entry(32'hA000_0003, 32'hC000_0003, 1'b1);
    ack = 1'b1; stop = 1'b1;
    @(negedge clk_cog);
    ack = 1'b0; stop = 1'b0;
    checks++;
    if (setvid !== 1'b1 || data !== 32'h0 || level !== 4'd1 || pixel !== 32'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_halt: got setvid=%b data=%h level=%0d pixel=%h busy=%b want 1 0 1 0 1",
               setvid, data, level, pixel, busy);
    end
    @(negedge clk_cog);
    checks++;
    if (setvid !== 1'b0 || busy !== 1'b0 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL stop_idle: got setvid=%b busy=%b underrun=%b want 0 0 1", setvid, busy, underrun);
    end
  endtask

  task automatic test_restart();
    logic [63:0] exp;
    start = 1'b1;
    @(negedge clk_cog);
    start = 1'b0;
    checks++;
    if (underrun !== 1'b0 || setscl !== 1'b1) begin
      errors++; $display("FAIL restart_clear: got underrun=%b setscl=%b want 0 1", underrun, setscl);
    end
    repeat (2) @(negedge clk_cog);
    exp = sb.pop_front();
    checks++;
    if ({pixel, color} !== exp || setvid !== 1'b1) begin
      errors++;
      $display("FAIL restart_prime: got pair=%h setvid=%b want %h 1", {pixel, color}, setvid, exp);
    end
    @(negedge clk_cog);
  endtask

  task automatic test_line_done();
    logic exp;
    for (int i = 1; i <= 9; i++) begin
      ack = 1'b1;
      @(negedge clk_cog);
      ack = 1'b0;
      exp = (i % 4 == 0);
      checks++;
      if (line_done !== exp) begin
        errors++; $display("FAIL line_done_edge%0d: got %b want %b", i, line_done, exp);
      end
      @(negedge clk_cog);
      checks++;
      if (line_done !== 1'b0) begin
        errors++; $display("FAIL line_done_pulse%0d: got %b want 0", i, line_done);
      end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] exp;
    for (int i = 0; i < 9; i++) begin
      push_entry(32'hB000_0000 + i, 32'hD000_0000 + i, i < 8);
      if (i == 7) begin
        checks++;
        if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL fill8: got level=%0d full=%b overflow=%b want 8 1 0", level, full, overflow);
        end
      end
      if (i == 8) begin
        checks++;
        if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b1) begin
          errors++;
          $display("FAIL overflow9: got level=%0d full=%b overflow=%b want 8 1 1", level, full, overflow);
        end
      end
    end
    push = 1'b1; push_pixel = 32'hE000_0000; push_color = 32'hF000_0000; ack = 1'b1;
    @(negedge clk_cog);
    push = 1'b0; ack = 1'b0;
    exp = sb.pop_front();
    sb.push_back({32'hE000_0000, 32'hF000_0000});
    checks++;
    if ({pixel, color} !== exp || level !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL push_pop_full: got pair=%h level=%0d overflow=%b want %h 8 1",
               {pixel, color}, level, overflow, exp);
    end
    @(negedge clk_cog);
    ack = 1'b1;
    @(negedge clk_cog);
    ack = 1'b0;
    exp = sb.pop_front();
    checks++;
    if ({pixel, color} !== exp || level !== 4'd7) begin
      errors++;
      $display("FAIL pop_after_full: got pair=%h level=%0d want %h 7", {pixel, color}, level, exp);
    end
  endtask

  task automatic test_ena_async();
    @(negedge clk_cog);
    #2 ena = 1'b0;
    #1;
    checks++;
    if ({setscl, setvid, data, pixel, color, full, busy, line_done, underrun, overflow} !== '0
        || level !== '0) begin
      errors++;
      $display("FAIL ena_clear: got pixel=%h color=%h level=%0d flags=%b%b%b%b%b%b%b want all 0",
               pixel, color, level, setscl, setvid, full, busy, line_done, underrun, overflow);
    end
    sb.delete();
    @(negedge clk_cog);
    ena = 1'b1;
    @(negedge clk_cog);
    checks++;
    if (busy !== 1'b0 || level !== '0 || setvid !== 1'b0) begin
      errors++;
      $display("FAIL ena_release: got busy=%b level=%0d setvid=%b want 0 0 0", busy, level, setvid);
    end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_ack_pop();
    test_underrun();
    test_stop_with_ack();
    test_restart();
    test_line_done();
    test_overflow();
    test_ena_async();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
